uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
- REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
- REQ-002 SHALL have parameter BAUD_FAST, default 9600, baud rate when baud_sel=1.
- REQ-003 SHALL have parameter BAUD_SLOW, default 2400, baud rate when baud_sel=0.
- REQ-004 SHALL have parameter DATA_W, default 8, tx_data width; legal value 8 only.
- REQ-005 SHALL have port clk  in  1  system clock; single clock domain, all flops on rising edge.
- REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
- REQ-007 SHALL have port tx_data  in  DATA_W  character to send, LSB first.
- REQ-008 SHALL have port tx_valid  in  1  character request.
- REQ-009 SHALL have port tx_ready  out  1  block can accept a character this cycle.
- REQ-010 SHALL have port wlen  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
- REQ-011 SHALL have port parity  in  2  parity mode: 00=none, 01=even, 10=odd, 11=space (constant 0).
- REQ-012 SHALL have port stop2  in  1  0 = one stop bit, 1 = two stop bits.
- REQ-013 SHALL have port baud_sel  in  1  1 = BAUD_FAST, 0 = BAUD_SLOW.
- REQ-014 SHALL have port busy  out  1  high while a frame is on the line.
- REQ-015 SHALL have port rts  out  1  request-to-send, high from first start bit to end of last stop bit of a burst.
- REQ-016 SHALL have port txd  out  1  serial line, idle high.

Function
- REQ-017 SHALL use bit period DIV = round(CLK_HZ/baud) clock cycles (50 MHz: 5208 fast, 20833 slow), from an internal counter enabled only while busy; no derived clocks.
- REQ-018 SHALL accept a character on the cycle where tx_valid and tx_ready are both high, latching tx_data, wlen, parity, stop2 and baud_sel; later changes SHALL NOT affect the frame in flight.
- REQ-019 SHALL drive txd low and rts, busy high on the cycle after acceptance; the bit counter SHALL restart there so the start bit lasts exactly DIV cycles.
- REQ-020 SHALL implement states IDLE -> START -> DATA -> PARITY -> STOP -> IDLE; PARITY is skipped when latched parity=00.
- REQ-021 SHALL send data bits LSB first, exactly wlen-coded count; bits above the word length are ignored.
- REQ-022 SHALL send parity bit: even = XOR of sent data bits, odd = its inverse, space = 0.
- REQ-023 SHALL hold txd high for 1 or 2 bit periods in STOP per latched stop2.
- REQ-024 SHALL drive tx_ready high in IDLE and during the last clock cycle of the final stop-bit period; low otherwise.
- REQ-025 SHALL, when a character is accepted in that final stop cycle, enter START on the next cycle with no idle gap, keeping rts and busy high (back-to-back burst).
- REQ-026 SHALL, when the final stop period ends without acceptance, return to IDLE and drive rts and busy low on the next cycle.
- REQ-027 SHALL have frame length 1 + wlen + (parity!=00) + (1+stop2) bit periods, each exactly DIV cycles.
- REQ-028 SHALL hold txd high whenever the state is IDLE.

Reset
- REQ-029 SHALL, with rst high, set txd=1, rts=0, busy=0, tx_ready=1, state IDLE, counters to 0 on the next edge.
- REQ-030 SHALL abort any frame when rst is asserted mid-frame: txd returns high next cycle, no partial-frame resume.
- REQ-031 SHALL ignore tx_valid during cycles where rst is high.

Verification
- REQ-032 SHALL cover 8N1 at 9600, 0x55 -> txd 0,1,0,1,0,1,0,1,0,1 each 5208 cycles; rts high for exactly 52080 cycles.
- REQ-033 SHALL cover 7E2 at 2400, 0x7F -> 7 ones, parity 1, 2 stop bits; frame 11*20833 cycles.
- REQ-034 SHALL cover 8O1, 0x00 -> parity bit 1; 5N1, 0xFF -> 5 ones then stop, frame 7*5208 cycles.
- REQ-035 SHALL cover back-to-back 0x00 then 0xFF with tx_valid held -> second start bit immediately after first stop, rts never drops, tx_ready pulses once per frame.
- REQ-036 SHALL cover rst asserted during DATA bit 3 -> txd=1, rts=0, busy=0 next cycle; new request then produces a full clean frame.
- REQ-037 SHALL cover wlen/parity changed mid-frame -> current frame unchanged, next frame uses new settings.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg -- configurable UART transmitter
//
// Sends one asynchronous character per request with a selectable word length
// (5..8 bits), parity (none/even/odd/space), one or two stop bits and one of
// two baud rates. The frame settings are captured at acceptance so the host
// may change them freely while a frame is on the line. A request accepted
// during the last clock of the final stop bit chains straight into the next
// start bit, so rts stays high across a burst of characters.
//
// Ports
//   clk       in   system clock, all flops on the rising edge
//   rst       in   synchronous active-high reset
//   tx_data   in   character to send, LSB first (bits above word length ignored)
//   tx_valid  in   character request
//   tx_ready  out  character is accepted on a cycle with tx_valid & tx_ready
//   wlen      in   word length: 00=5, 01=6, 10=7, 11=8 bits
//   parity    in   00=none, 01=even, 10=odd, 11=space (always 0)
//   stop2     in   0 = one stop bit, 1 = two stop bits
//   baud_sel  in   1 = BAUD_FAST, 0 = BAUD_SLOW
//   busy      out  high while a frame is on the line
//   rts       out  high from the first start bit to the end of the last stop
//                  bit of a burst
//   txd       out  serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD_FAST = 9600,
  parameter int BAUD_SLOW = 2400,
  parameter int DATA_W    = 8            // only 8 is supported
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [1:0]        wlen,
  input  logic [1:0]        parity,
  input  logic              stop2,
  input  logic              baud_sel,
  output logic              busy,
  output logic              rts,
  output logic              txd
);

  // Bit period in clock cycles, rounded to nearest.
  localparam int DIV_FAST = (CLK_HZ + BAUD_FAST / 2) / BAUD_FAST;
  localparam int DIV_SLOW = (CLK_HZ + BAUD_SLOW / 2) / BAUD_SLOW;
  localparam int DIV_MAX  = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
  localparam int CNT_W    = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(DIV_FAST - 1);
  localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(DIV_SLOW - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;          // cycle within the current bit period
  logic [2:0]        bit_idx;      // data bit being sent
  logic              stop_idx;     // stop bit being sent (0 or 1)
  logic [DATA_W-1:0] shreg;        // remaining data bits, current bit at [0]
  logic              par_acc;      // XOR of data bits already sent
  logic [1:0]        wlen_q;
  logic [1:0]        parity_q;
  logic              stop2_q;
  logic              baud_q;

  logic [CNT_W-1:0]  cnt_last;
  logic              bit_end;
  logic              data_last;
  logic              stop_last;
  logic              par_next;
  logic              par_bit;
  logic              accept;

  assign cnt_last  = baud_q ? LAST_FAST : LAST_SLOW;
  assign bit_end   = (cnt == cnt_last);

  // Word length 5..8 maps to last bit index 4..7, i.e. {1, wlen}.
  assign data_last = (bit_idx == {1'b1, wlen_q});
  assign stop_last = (stop_idx == stop2_q);

  // Parity over all sent data bits including the one currently on the line.
  assign par_next  = par_acc ^ shreg[0];

  // NOTE: every output of a combinational block gets a value on every path
  // (here through the default arm) so no latch is inferred.
  always_comb begin
    case (parity_q)
      2'b01:   par_bit = par_next;
      2'b10:   par_bit = ~par_next;
      default: par_bit = 1'b0;
    endcase
  end

  // Ready in IDLE and in the very last clock of the final stop bit, which is
  // what lets a burst run with no idle gap between frames.
  assign tx_ready = (state == S_IDLE) ||
                    ((state == S_STOP) && stop_last && bit_end);

  // rst has priority inside the flop block, so a request during reset is
  // never seen.
  assign accept = tx_valid && tx_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      wlen_q   <= '0;
      parity_q <= '0;
      stop2_q  <= 1'b0;
      baud_q   <= 1'b0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      rts      <= 1'b0;
    end else if (accept) begin
      // New frame: capture settings and start the bit timer afresh so the
      // start bit lasts exactly one full period.
      state    <= S_START;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= tx_data;
      par_acc  <= 1'b0;
      wlen_q   <= wlen;
      parity_q <= parity;
      stop2_q  <= stop2;
      baud_q   <= baud_sel;
      txd      <= 1'b0;
      busy     <= 1'b1;
      rts      <= 1'b1;
    end else begin
      // Bit timer runs only while a frame is on the line.
      if (state != S_IDLE) begin
        cnt <= bit_end ? '0 : cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          txd  <= 1'b1;
          busy <= 1'b0;
          rts  <= 1'b0;
        end

        S_START: begin
          if (bit_end) begin
            state <= S_DATA;
            txd   <= shreg[0];
          end
        end

        S_DATA: begin
          if (bit_end) begin
            if (data_last) begin
              if (parity_q != 2'b00) begin
                state <= S_PARITY;
                txd   <= par_bit;
              end else begin
                state <= S_STOP;
                txd   <= 1'b1;
              end
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              par_acc <= par_next;
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            state    <= S_STOP;
            stop_idx <= 1'b0;
            txd      <= 1'b1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            if (!stop_last) begin
              stop_idx <= 1'b1;
            end else begin
              // Final stop bit over with no new request: end of burst.
              state <= S_IDLE;
              txd   <= 1'b1;
              busy  <= 1'b0;
              rts   <= 1'b0;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          txd   <= 1'b1;
          busy  <= 1'b0;
          rts   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_cfg -- self-checking bench for uart_tx_cfg
//
// A reduced clock (100 kHz) keeps frames short: fast bit period
// round(100000/9600) = 10 cycles, slow round(100000/2400) = 42 cycles.
// Expected frames are built from the requested settings and queued when a
// character is accepted; a monitor pops them at each start bit and checks the
// line level of every cycle of every bit.
// -----------------------------------------------------------------------------
module tb_uart_tx_cfg;

  localparam int CLK_HZ    = 100_000;
  localparam int BAUD_FAST = 9600;
  localparam int BAUD_SLOW = 2400;
  localparam int DIV_F     = 10;
  localparam int DIV_S     = 42;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [1:0] wlen = 2'b11;
  logic [1:0] parity = 2'b00;
  logic       stop2 = 1'b0;
  logic       baud_sel = 1'b1;
  logic       busy;
  logic       rts;
  logic       txd;

  uart_tx_cfg #(
    .CLK_HZ   (CLK_HZ),
    .BAUD_FAST(BAUD_FAST),
    .BAUD_SLOW(BAUD_SLOW),
    .DATA_W   (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .wlen    (wlen),
    .parity  (parity),
    .stop2   (stop2),
    .baud_sel(baud_sel),
    .busy    (busy),
    .rts     (rts),
    .txd     (txd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          div;
  } frame_t;

  frame_t sb[$];
  string  sb_tag[$];
  int     total = 0;
  int     bad = 0;
  bit     mon_en = 1'b1;

  // Free-running observers, each variable written only here.
  int   cyc = 0;
  int   rts_cnt = 0;
  int   rts_falls = 0;
  int   ready_pulses = 0;
  logic rts_d = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rts === 1'b1) rts_cnt++;
    if (rts_d === 1'b1 && rts === 1'b0) rts_falls++;
    if (tx_ready === 1'b1 && busy === 1'b1) ready_pulses++;
    rts_d = rts;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] d, input logic [1:0] wl,
                                input logic [1:0] par, input logic s2, input logic bsel);
    frame_t f;
    int     n;
    int     k;
    logic   p;
    n = 5 + int'(wl);
    p = 1'b0;
    f.bits = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      f.bits[1 + i] = d[i];
      p = p ^ d[i];
    end
    k = 1 + n;
    if (par != 2'b00) begin
      f.bits[k] = (par == 2'b01) ? p : (par == 2'b10) ? ~p : 1'b0;
      k++;
    end
    f.bits[k] = 1'b1;
    k++;
    if (s2) begin
      f.bits[k] = 1'b1;
      k++;
    end
    f.nbits = k;
    f.div   = bsel ? DIV_F : DIV_S;
    return f;
  endfunction

  // Monitor: on each start bit pop the next expected frame and check txd on
  // every cycle, with rts and busy high throughout.
  initial begin : monitor
    frame_t f;
    string  tag;
    bit     ok_bit;
    bit     ok_ctl;
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        check("start_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          f   = sb.pop_front();
          tag = sb_tag.pop_front();
          ok_ctl = 1'b1;
          for (int b = 0; b < f.nbits; b++) begin
            ok_bit = 1'b1;
            for (int c = 0; c < f.div; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (txd !== f.bits[b]) ok_bit = 1'b0;
              if (rts !== 1'b1 || busy !== 1'b1) ok_ctl = 1'b0;
            end
            check($sformatf("%s_bit%0d", tag, b), 32'(ok_bit), 32'd1);
          end
          check({tag, "_rts_busy_held"}, 32'(ok_ctl), 32'd1);
        end
      end
    end
  end

  // Offer a character at a negedge and wait (bounded) until it is accepted.
  // Returns at the negedge after acceptance, having checked the start of frame.
  task automatic send(input string tag, input logic [7:0] d, input logic [1:0] wl,
                      input logic [1:0] par, input logic s2, input logic bsel,
                      input bit push, input bit keep_valid, output int acc_cyc);
    int n;
    n = 0;
    tx_data  = d;
    wlen     = wl;
    parity   = par;
    stop2    = s2;
    baud_sel = bsel;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_seen"}, 32'(tx_ready), 32'd1);
    if (push) begin
      sb.push_back(mk(d, wl, par, s2, bsel));
      sb_tag.push_back(tag);
    end
    @(posedge clk);
    acc_cyc = cyc;
    @(negedge clk);
    if (!keep_valid) tx_valid = 1'b0;
    check({tag, "_start_txd_busy_rts_ready"}, 32'({txd, busy, rts, tx_ready}), 32'b0110);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_txd_rts"}, 32'({txd, rts}), 32'b10);
  endtask

  initial begin : stim
    int  a0;
    int  a1;
    int  base_rts;
    int  base_falls;
    int  base_ready;
    bit  ok;

    // Reset, with a request held during reset that must be ignored.
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({txd, rts, busy, tx_ready}), 32'b1001);
    rst      = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    check("reset_valid_ignored", 32'({busy, txd}), 32'b01);
    repeat (3) @(negedge clk);

    // 8N1 fast, 0x55.
    base_rts = rts_cnt;
    send("8n1_55", 8'h55, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, a0);
    wait_idle("8n1_55");
    check("8n1_55_rts_cycles", 32'(rts_cnt - base_rts), 32'(10 * DIV_F));

    // 7E2 slow, 0x7F.
    base_rts = rts_cnt;
    send("7e2_7f", 8'h7F, 2'b10, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, a0);
    wait_idle("7e2_7f");
    check("7e2_7f_rts_cycles", 32'(rts_cnt - base_rts), 32'(11 * DIV_S));

    // 8O1 fast, 0x00 -> parity bit 1.
    base_rts = rts_cnt;
    send("8o1_00", 8'h00, 2'b11, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, a0);
    wait_idle("8o1_00");
    check("8o1_00_rts_cycles", 32'(rts_cnt - base_rts), 32'(11 * DIV_F));

    // 5N1 fast, 0xFF -> only five data bits.
    base_rts = rts_cnt;
    send("5n1_ff", 8'hFF, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, a0);
    wait_idle("5n1_ff");
    check("5n1_ff_rts_cycles", 32'(rts_cnt - base_rts), 32'(7 * DIV_F));

    // 6S1 fast, 0x2A -> space parity.
    send("6s1_2a", 8'h2A, 2'b01, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, a0);
    wait_idle("6s1_2a");

    // Back-to-back 0x00 then 0xFF with tx_valid held.
    base_rts   = rts_cnt;
    base_falls = rts_falls;
    base_ready = ready_pulses;
    send("b2b_00", 8'h00, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, a0);
    send("b2b_ff", 8'hFF, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, a1);
    check("b2b_accept_spacing", 32'(a1 - a0), 32'(10 * DIV_F));
    wait_idle("b2b");
    check("b2b_rts_cycles", 32'(rts_cnt - base_rts), 32'(20 * DIV_F));
    check("b2b_rts_falls", 32'(rts_falls - base_falls), 32'd1);
    check("b2b_ready_pulses", 32'(ready_pulses - base_ready), 32'd2);

    // Reset in the middle of data bit 3 of an unchecked frame.
    mon_en = 1'b0;
    send("abort", 8'hA5, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, a0);
    repeat (44) @(negedge clk);
    check("abort_in_bit3", 32'(txd), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", 32'({txd, rts, busy, tx_ready}), 32'b1001);
    rst = 1'b0;
    ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || rts !== 1'b0) ok = 1'b0;
    end
    check("abort_no_resume", 32'(ok), 32'd1);
    mon_en = 1'b1;
    base_rts = rts_cnt;
    send("after_abort", 8'h3C, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, a0);
    wait_idle("after_abort");
    check("after_abort_rts_cycles", 32'(rts_cnt - base_rts), 32'(10 * DIV_F));

    // Settings changed mid-frame must not disturb the frame in flight.
    base_rts = rts_cnt;
    send("cfg_old", 8'h15, 2'b10, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, a0);
    tx_data  = 8'hFF;
    wlen     = 2'b11;
    parity   = 2'b10;
    stop2    = 1'b1;
    baud_sel = 1'b0;
    wait_idle("cfg_old");
    check("cfg_old_rts_cycles", 32'(rts_cnt - base_rts), 32'(10 * DIV_F));
    base_rts = rts_cnt;
    send("cfg_new", 8'h81, 2'b11, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, a0);
    wait_idle("cfg_new");
    check("cfg_new_rts_cycles", 32'(rts_cnt - base_rts), 32'(12 * DIV_S));

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
